ysyx_22041211_ifu: RTL

Instruction fetch unit for the ysyx_22041211 core. It owns the program counter and issues one read per instruction on an AXI-lite-style read channel toward instruction memory. It presents each returned instruction to the decoder over a valid/ready handshake. The next PC comes from the execute stage at handshake time, which replaces the free-running counter and the direct memory read in the current core.

---
 rtl/ysyx_22041211_pkg.sv | 14 +
 rtl/ysyx_22041211_ifu_perf.sv | 27 ++
 rtl/ysyx_22041211_ifu.sv | 94 +++++++++
 3 files changed

// File: rtl/ysyx_22041211_pkg.sv
// Shared types and constants for the ysyx_22041211 core.
package ysyx_22041211_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_ifu_perf.sv
// Fetch performance counters: consumed instructions and cycles spent waiting on memory.
module ysyx_22041211_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: one AXI-lite read per instruction, valid/ready hand-off to decode.
// Define YSYX_22041211_IFU_PERF_EN to add the fetch/stall performance counters.
module ysyx_22041211_ifu
  import ysyx_22041211_pkg::*;
#(
  parameter int unsigned         DATA_LEN = 32,
  parameter int unsigned         ADDR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                fault_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  input  logic                redirect_i,
  input  logic [ADDR_LEN-1:0] redirect_pc_i
`ifdef YSYX_22041211_IFU_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt,
  output logic [63:0]         perf_stall_cnt
`endif
);

  ifu_state_e          state_q;
  logic [ADDR_LEN-1:0] pc_q;
  logic [DATA_LEN-1:0] inst_q;
  logic                fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (arready) state_q <= StWait;
        end
        StWait: begin
          if (rvalid) begin
            inst_q  <= rdata;
            fault_q <= (rresp != RESP_OKAY);
            state_q <= StHold;
          end
        end
        StHold: begin
          // Redirect only matters on the consume beat; PC wraps naturally.
          if (inst_ready_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : pc_q + ADDR_LEN'(4);
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arvalid      = (state_q == StReq);
  assign rready       = (state_q == StWait);
  assign inst_valid_o = (state_q == StHold);
  assign araddr       = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign fault_o      = fault_q;

`ifdef YSYX_22041211_IFU_PERF_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = inst_valid_o & inst_ready_i;
  assign stall_inc = arvalid | rready;

  ysyx_22041211_ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (fetch_inc),
    .stall_inc      (stall_inc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
